// File: rtl/nco_sweep_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : nco_sweep_ctrl_if
// Brief    : Control/configuration and NCO drive bundle for nco_sweep_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
interface nco_sweep_ctrl_if #(
    parameter int FW = 11,
    parameter int AW = 8,
    parameter int DW = 16
);
    logic          start;
    logic          abort;
    logic [FW-1:0] cfg_f_start;
    logic [FW-1:0] cfg_f_stop;
    logic [FW-1:0] cfg_f_step;
    logic [DW-1:0] cfg_dwell;
    logic [AW-1:0] cfg_amp;
    logic          cfg_loop;
    logic [FW-1:0] freq_word;
    logic [AW-1:0] amp;
    logic          nco_en;
    logic          busy;
    logic          done;

    modport master (
        output start, abort, cfg_f_start, cfg_f_stop, cfg_f_step,
               cfg_dwell, cfg_amp, cfg_loop,
        input  freq_word, amp, nco_en, busy, done
    );

    modport slave (
        input  start, abort, cfg_f_start, cfg_f_stop, cfg_f_step,
               cfg_dwell, cfg_amp, cfg_loop,
        output freq_word, amp, nco_en, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/nco_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : nco_sweep_ctrl
// Brief    : Click-free NCO frequency sweep sequencer (fade in, sweep, fade out).
// Revision : 1.0 - initial release
// ============================================================================
module nco_sweep_ctrl #(
    parameter int FW       = 11,
    parameter int AW       = 8,
    parameter int DW       = 16,
    parameter int AMP_STEP = 8
) (
    input  logic               clk,
    input  logic               rst,
    nco_sweep_ctrl_if.slave    bus
);

    localparam logic [1:0]  c_IDLE      = 2'd0;
    localparam logic [1:0]  c_RAMP_UP   = 2'd1;
    localparam logic [1:0]  c_SWEEP     = 2'd2;
    localparam logic [1:0]  c_RAMP_DOWN = 2'd3;
    localparam logic [AW:0] c_AMP_STEP  = AMP_STEP[AW:0];

    logic [1:0]    r_state,   w_state;
    logic [FW-1:0] r_f_start, w_f_start;
    logic [FW-1:0] r_f_stop,  w_f_stop;
    logic [FW-1:0] r_f_step,  w_f_step;
    logic [DW-1:0] r_dwell,   w_dwell;
    logic [AW-1:0] r_amp_tgt, w_amp_tgt;
    logic          r_loop,    w_loop;
    logic          r_up,      w_up;
    logic [DW-1:0] r_cnt,     w_cnt;
    logic [FW-1:0] r_freq,    w_freq;
    logic [AW-1:0] r_amp,     w_amp;
    logic          r_en,      w_en;
    logic          r_busy,    w_busy;
    logic          r_done,    w_done;

    logic [AW:0]   w_amp_inc;
    logic [AW:0]   w_amp_dec;
    logic [FW:0]   w_f_inc;
    logic [FW:0]   w_f_dec;
    logic [FW-1:0] w_f_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_f_start <= '0;
            r_f_stop  <= '0;
            r_f_step  <= '0;
            r_dwell   <= '0;
            r_amp_tgt <= '0;
            r_loop    <= 1'b0;
            r_up      <= 1'b0;
            r_cnt     <= '0;
            r_freq    <= '0;
            r_amp     <= '0;
            r_en      <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_f_start <= w_f_start;
            r_f_stop  <= w_f_stop;
            r_f_step  <= w_f_step;
            r_dwell   <= w_dwell;
            r_amp_tgt <= w_amp_tgt;
            r_loop    <= w_loop;
            r_up      <= w_up;
            r_cnt     <= w_cnt;
            r_freq    <= w_freq;
            r_amp     <= w_amp;
            r_en      <= w_en;
            r_busy    <= w_busy;
            r_done    <= w_done;
        end
    end

    always_comb begin
        w_state   = r_state;
        w_f_start = r_f_start;
        w_f_stop  = r_f_stop;
        w_f_step  = r_f_step;
        w_dwell   = r_dwell;
        w_amp_tgt = r_amp_tgt;
        w_loop    = r_loop;
        w_up      = r_up;
        w_cnt     = r_cnt;
        w_freq    = r_freq;
        w_amp     = r_amp;
        w_en      = r_en;
        w_busy    = r_busy;
        w_done    = 1'b0;

        // One extra bit so overshoot (up) and borrow (down) are visible for clamping.
        w_amp_inc = {1'b0, r_amp} + c_AMP_STEP;
        w_amp_dec = {1'b0, r_amp} - c_AMP_STEP;
        w_f_inc   = {1'b0, r_freq} + {1'b0, r_f_step};
        w_f_dec   = {1'b0, r_freq} - {1'b0, r_f_step};
        if (r_up) begin
            w_f_next = (w_f_inc >= {1'b0, r_f_stop}) ? r_f_stop : w_f_inc[FW-1:0];
        end else begin
            w_f_next = (w_f_dec[FW] || (w_f_dec[FW-1:0] <= r_f_stop)) ? r_f_stop
                                                                      : w_f_dec[FW-1:0];
        end

        case (r_state)
            c_IDLE: begin
                if (bus.start && !bus.abort && (bus.cfg_f_step != '0) && (bus.cfg_dwell != '0)) begin
                    w_f_start = bus.cfg_f_start;
                    w_f_stop  = bus.cfg_f_stop;
                    w_f_step  = bus.cfg_f_step;
                    w_dwell   = bus.cfg_dwell;
                    w_amp_tgt = bus.cfg_amp;
                    w_loop    = bus.cfg_loop;
                    w_up      = (bus.cfg_f_start <= bus.cfg_f_stop);
                    w_freq    = bus.cfg_f_start;
                    w_amp     = '0;
                    w_en      = 1'b1;
                    w_busy    = 1'b1;
                    w_state   = c_RAMP_UP;
                end
            end
            c_RAMP_UP: begin
                if (bus.abort) begin
                    w_state = c_RAMP_DOWN;
                end else if (w_amp_inc >= {1'b0, r_amp_tgt}) begin
                    w_amp   = r_amp_tgt;
                    w_cnt   = r_dwell - 1'b1;
                    w_state = c_SWEEP;
                end else begin
                    w_amp = w_amp_inc[AW-1:0];
                end
            end
            c_SWEEP: begin
                if (bus.abort) begin
                    w_state = c_RAMP_DOWN;
                end else if (r_cnt != '0) begin
                    w_cnt = r_cnt - 1'b1;
                end else if (r_freq != r_f_stop) begin
                    w_freq = w_f_next;
                    w_cnt  = r_dwell - 1'b1;
                end else if (r_loop) begin
                    w_freq = r_f_start;
                    w_cnt  = r_dwell - 1'b1;
                end else begin
                    w_state = c_RAMP_DOWN;
                end
            end
            c_RAMP_DOWN: begin
                if (w_amp_dec[AW] || (w_amp_dec[AW-1:0] == '0)) begin
                    w_amp   = '0;
                    w_en    = 1'b0;
                    w_busy  = 1'b0;
                    w_done  = 1'b1;
                    w_state = c_IDLE;
                end else begin
                    w_amp = w_amp_dec[AW-1:0];
                end
            end
            default: w_state = c_IDLE;
        endcase
    end

    assign bus.freq_word = r_freq;
    assign bus.amp       = r_amp;
    assign bus.nco_en    = r_en;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_nco_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_nco_sweep_ctrl
// Brief    : Directed self-checking bench for nco_sweep_ctrl (AMP_STEP = 50).
// Revision : 1.0 - initial release
// ============================================================================
module tb_nco_sweep_ctrl;
    localparam int FW       = 11;
    localparam int AW       = 8;
    localparam int DW       = 16;
    localparam int AMP_STEP = 50;

    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   ef;
    int   ea;

    nco_sweep_ctrl_if #(.FW(FW), .AW(AW), .DW(DW)) bus ();

    nco_sweep_ctrl #(.FW(FW), .AW(AW), .DW(DW), .AMP_STEP(AMP_STEP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input int fw, input int am,
                           input int en, input int bz, input int dn);
        chk({tag, "_freq"}, 32'(bus.freq_word), fw);
        chk({tag, "_amp"},  32'(bus.amp),       am);
        chk({tag, "_en"},   32'(bus.nco_en),    en);
        chk({tag, "_busy"}, 32'(bus.busy),      bz);
        chk({tag, "_done"}, 32'(bus.done),      dn);
    endtask

    task automatic cfg(input int fs, input int fe, input int st,
                       input int dw, input int am, input int lp);
        bus.cfg_f_start = fs[FW-1:0];
        bus.cfg_f_stop  = fe[FW-1:0];
        bus.cfg_f_step  = st[FW-1:0];
        bus.cfg_dwell   = dw[DW-1:0];
        bus.cfg_amp     = am[AW-1:0];
        bus.cfg_loop    = lp[0];
    endtask

    initial begin
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        cfg(0, 0, 0, 0, 0, 0);
        tick();
        tick();
        chk_out("reset", 0, 0, 0, 0, 0);
        rst = 1'b0;
        tick();

        // Up sweep 32->40 step 4, dwell 3, amp 250; cfg edits and a start mid-run must be ignored
        cfg(32, 40, 4, 3, 250, 0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk_out("up_e0", 32, 0, 1, 1, 0);
        bus.cfg_f_start = 11'd7;
        bus.cfg_amp     = 8'd10;
        for (int k = 1; k <= 19; k++) begin
            if (k == 9) bus.start = 1'b1;
            tick();
            bus.start = 1'b0;
            ef = (k <= 7) ? 32 : (k <= 10) ? 36 : 40;
            ea = (k <= 5) ? 50 * k : (k <= 14) ? 250 : 250 - 50 * (k - 14);
            chk("up_freq", 32'(bus.freq_word), ef);
            chk("up_amp",  32'(bus.amp), ea);
            chk("up_done", 32'(bus.done), (k == 19) ? 1 : 0);
            chk("up_busy", 32'(bus.busy), (k == 19) ? 0 : 1);
            chk("up_en",   32'(bus.nco_en), (k == 19) ? 0 : 1);
        end
        tick();
        chk("up_done_once", 32'(bus.done), 0);

        // Degenerate / ignored starts
        cfg(32, 40, 0, 3, 250, 0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("step0_busy", 32'(bus.busy), 0);
        tick();
        chk("step0_done", 32'(bus.done), 0);
        cfg(32, 40, 4, 0, 250, 0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("dwell0_busy", 32'(bus.busy), 0);
        tick();
        chk("dwell0_done", 32'(bus.done), 0);
        cfg(32, 40, 4, 3, 250, 0);
        bus.start = 1'b1;
        bus.abort = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        chk("stab_busy", 32'(bus.busy), 0);
        chk("stab_en",   32'(bus.nco_en), 0);
        tick();
        chk("stab_done", 32'(bus.done), 0);

        // Down sweep 40->30 step 4, dwell 2, amp 100: 40,36,32,30 (clamped)
        cfg(40, 30, 4, 2, 100, 0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk_out("dn_e0", 40, 0, 1, 1, 0);
        for (int k = 1; k <= 12; k++) begin
            tick();
            ef = (k <= 3) ? 40 : (k <= 5) ? 36 : (k <= 7) ? 32 : 30;
            ea = (k == 1) ? 50 : (k <= 10) ? 100 : (k == 11) ? 50 : 0;
            chk("dn_freq", 32'(bus.freq_word), ef);
            chk("dn_amp",  32'(bus.amp), ea);
            chk("dn_done", 32'(bus.done), (k == 12) ? 1 : 0);
        end

        // Back-to-back start during done, loop mode, then abort at 36
        cfg(32, 40, 4, 3, 250, 1);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk_out("lp_e0", 32, 0, 1, 1, 0);
        for (int k = 1; k <= 17; k++) begin
            tick();
            ef = (k <= 7) ? 32 : (k <= 10) ? 36 : (k <= 13) ? 40 : (k <= 16) ? 32 : 36;
            ea = (k <= 5) ? 50 * k : 250;
            chk("lp_freq", 32'(bus.freq_word), ef);
            chk("lp_amp",  32'(bus.amp), ea);
        end
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk_out("ab_e0", 36, 250, 1, 1, 0);
        for (int k = 19; k <= 23; k++) begin
            tick();
            chk("ab_freq", 32'(bus.freq_word), 36);
            chk("ab_amp",  32'(bus.amp), 250 - 50 * (k - 18));
            chk("ab_done", 32'(bus.done), (k == 23) ? 1 : 0);
        end
        tick();

        // Reset in the middle of a sweep
        cfg(32, 40, 4, 3, 250, 0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (7) tick();
        chk("mid_busy_pre", 32'(bus.busy), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_out("mid_rst", 0, 0, 0, 0, 0);
        tick();
        chk("mid_idle_busy", 32'(bus.busy), 0);

        // Edge config: amp 0 and f_start = f_stop = 100, dwell 5
        cfg(100, 100, 4, 5, 0, 0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk_out("edge_e0", 100, 0, 1, 1, 0);
        for (int k = 1; k <= 7; k++) begin
            tick();
            chk("edge_freq", 32'(bus.freq_word), 100);
            chk("edge_amp",  32'(bus.amp), 0);
            chk("edge_busy", 32'(bus.busy), (k == 7) ? 0 : 1);
            chk("edge_done", 32'(bus.done), (k == 7) ? 1 : 0);
        end
        tick();
        chk("edge_done_once", 32'(bus.done), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
